// File: rtl/decode_stage.sv
// Registered instruction-decode stage: splits the word into fields, extends the immediate,
// builds read/write enables and carries a one-entry skid buffer so in_ready is a flop.
module decode_stage #(
   parameter int OPW = 4,
   parameter int RW  = 4,
   parameter int DW  = 16,
   localparam int IW = OPW + 3*RW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] in_instr,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OPW-1:0] out_opcode,
   output logic [RW-1:0] out_dr,
   output logic [RW-1:0] out_sa,
   output logic [RW-1:0] out_sb,
   output logic [DW-1:0] out_imm,
   output logic          out_rd_a_en,
   output logic          out_rd_b_en,
   output logic          out_wr_en,
   output logic          out_illegal,
   output logic          halted
);

   typedef struct packed {
      logic [OPW-1:0] opcode;
      logic [RW-1:0]  dr;
      logic [RW-1:0]  sa;
      logic [RW-1:0]  sb;
      logic [DW-1:0]  imm;
      logic           rd_a;
      logic           rd_b;
      logic           wr;
      logic           illegal;
   } bundle_t;

   // Bit 0 of the occupancy state doubles as out_valid so that output comes straight off a flop.
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] ONE   = 2'b01;
   localparam logic [1:0] TWO   = 2'b11;

   logic [1:0] state_reg, state_next;
   bundle_t    out_reg, out_next;
   bundle_t    skid_reg, skid_next;
   logic       halted_reg, halted_next;
   logic       in_ready_reg, in_ready_next;

   logic [OPW-1:0]  op;
   logic [RW-1:0]   f1, f2, f3;
   logic [2*RW-1:0] imm_raw;
   bundle_t         dec_in;
   logic            eoe_in;
   logic            in_xfer, out_xfer;

   assign op      = in_instr[IW-1 -: OPW];
   assign f1      = in_instr[3*RW-1 -: RW];
   assign f2      = in_instr[2*RW-1 -: RW];
   assign f3      = in_instr[RW-1:0];
   assign imm_raw = in_instr[2*RW-1:0];
   assign eoe_in  = (op == OPW'(15)) && (f3 == RW'(1));

   always_comb begin
      dec_in        = '0;
      dec_in.opcode = op;
      case (op)
         OPW'(0), OPW'(1), OPW'(2), OPW'(3), OPW'(4), OPW'(5), OPW'(6), OPW'(7): begin
            dec_in.dr   = f1;
            dec_in.sa   = f2;
            dec_in.sb   = f3;
            dec_in.rd_a = 1'b1;
            dec_in.rd_b = (op != OPW'(5));
            dec_in.wr   = 1'b1;
         end
         OPW'(8): begin
            dec_in.dr  = f1;
            dec_in.imm = DW'(signed'(imm_raw));
            dec_in.wr  = 1'b1;
         end
         OPW'(9), OPW'(10): begin
            dec_in.dr   = f1;
            dec_in.sa   = f2;
            dec_in.sb   = f3;
            dec_in.rd_a = 1'b1;
            dec_in.rd_b = 1'b1;
            dec_in.wr   = (op == OPW'(9));
         end
         OPW'(11), OPW'(12): begin
            dec_in.sa   = f1;
            dec_in.imm  = DW'(signed'(imm_raw));
            dec_in.rd_a = 1'b1;
         end
         OPW'(13), OPW'(14): begin
            dec_in.dr  = f1;
            dec_in.imm = DW'(imm_raw);
            dec_in.wr  = (op == OPW'(13));
         end
         OPW'(15): begin
            dec_in.dr = f1;
            dec_in.sa = f2;
            if (f3 == RW'(0)) begin
               dec_in.rd_a = 1'b1;
            end else if (f3 != RW'(1)) begin
               dec_in.sb      = f3;
               dec_in.illegal = 1'b1;
            end
         end
         default: begin
            // Opcodes beyond the defined set (wider OPW) decode as reserved.
            dec_in.dr      = f1;
            dec_in.sa      = f2;
            dec_in.sb      = f3;
            dec_in.illegal = 1'b1;
         end
      endcase
   end

   assign in_xfer  = in_valid && in_ready_reg && !flush;
   assign out_xfer = state_reg[0] && out_ready;

   always_comb begin
      state_next = state_reg;
      out_next   = out_reg;
      skid_next  = skid_reg;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (in_xfer) begin
                  out_next   = dec_in;
                  state_next = ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  out_next = dec_in;
               end else if (in_xfer) begin
                  skid_next  = dec_in;
                  state_next = TWO;
               end else if (out_xfer) begin
                  state_next = EMPTY;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  out_next   = skid_reg;
                  state_next = ONE;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
      halted_next   = halted_reg || (in_xfer && eoe_in);
      in_ready_next = (state_next != TWO) && !halted_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         out_reg      <= '0;
         skid_reg     <= '0;
         halted_reg   <= 1'b0;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         out_reg      <= out_next;
         skid_reg     <= skid_next;
         halted_reg   <= halted_next;
         in_ready_reg <= in_ready_next;
      end
   end

   assign in_ready    = in_ready_reg;
   assign out_valid   = state_reg[0];
   assign halted      = halted_reg;
   assign out_opcode  = out_reg.opcode;
   assign out_dr      = out_reg.dr;
   assign out_sa      = out_reg.sa;
   assign out_sb      = out_reg.sb;
   assign out_imm     = out_reg.imm;
   assign out_rd_a_en = out_reg.rd_a;
   assign out_rd_b_en = out_reg.rd_b;
   assign out_wr_en   = out_reg.wr;
   assign out_illegal = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage: a queue-based occupancy model plus a flag-based decoder
// predicts every output each cycle; directed sequences pin the documented example encodings.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_instr = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_opcode, out_dr, out_sa, out_sb;
   logic [15:0] out_imm;
   logic        out_rd_a_en, out_rd_b_en, out_wr_en, out_illegal, halted;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_dr(out_dr), .out_sa(out_sa), .out_sb(out_sb), .out_imm(out_imm),
      .out_rd_a_en(out_rd_a_en), .out_rd_b_en(out_rd_b_en), .out_wr_en(out_wr_en),
      .out_illegal(out_illegal), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [35:0] dut_bundle;
   assign dut_bundle = {out_opcode, out_dr, out_sa, out_sb, out_imm,
                        out_rd_a_en, out_rd_b_en, out_wr_en, out_illegal};

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Decoder expressed as per-field membership rules over the opcode set.
   function automatic logic [35:0] ref_dec(input logic [15:0] w);
      int op, a, b, c;
      logic [7:0]  i8;
      logic        ill, three, ra, rb, wr;
      logic [3:0]  dr, sa, sb;
      logic [15:0] imm;
      op = int'(w[15:12]); a = int'(w[11:8]); b = int'(w[7:4]); c = int'(w[3:0]);
      i8 = w[7:0];
      ill   = (op == 15) && (c >= 2);
      three = (op <= 10 && op != 8) || ill;
      ra    = (op <= 7) || op == 9 || op == 10 || op == 11 || op == 12 || (op == 15 && c == 0);
      rb    = (op <= 7 && op != 5) || op == 9 || op == 10;
      wr    = (op <= 9) || op == 13;
      dr    = (three || op == 8 || op == 13 || op == 14 || op == 15) ? 4'(a) : 4'd0;
      sa    = (op == 11 || op == 12) ? 4'(a) : ((three || op == 15) ? 4'(b) : 4'd0);
      sb    = three ? 4'(c) : 4'd0;
      if (op == 8 || op == 11 || op == 12) imm = 16'(signed'(i8));
      else if (op == 13 || op == 14)       imm = {8'h00, i8};
      else                                 imm = 16'h0000;
      return {w[15:12], dr, sa, sb, imm, ra, rb, wr, ill};
   endfunction

   logic [15:0] q[$];
   logic        m_halt = 1'b0;
   logic        m_rdy = 1'b1;

   // One clock: check outputs at the negedge, drive, update the model at the posedge, then idle inputs.
   task automatic step(input logic iv, input logic [15:0] ins, input logic ordy, input logic fl);
      logic in_x, out_x;
      @(negedge clk);
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, m_rdy);
      check("halted", halted, m_halt);
      if (q.size() > 0) check("bundle", dut_bundle, ref_dec(q[0]));
      in_valid = iv; in_instr = ins; out_ready = ordy; flush = fl;
      @(posedge clk);
      in_x  = iv && m_rdy && !fl;
      out_x = (q.size() > 0) && ordy;
      if (out_x) $display("[TB] t=%0t deliver %h%s", $time, q[0], fl ? " (flush)" : "");
      if (fl) q.delete();
      else begin
         if (out_x) void'(q.pop_front());
         if (in_x) q.push_back(ins);
      end
      if (in_x && ins[15:12] == 4'hF && ins[3:0] == 4'h1) m_halt = 1'b1;
      m_rdy = (q.size() < 2) && !m_halt;
      #2;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_halted", halted, 0);
      check("rst_bundle", dut_bundle, 0);
      q.delete(); m_halt = 1'b0; m_rdy = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      logic [15:0] ins;
      do_reset();
      // T1/T2: documented encodings
      step(1, 16'h1234, 1, 0); check("t1_sub", dut_bundle, 36'h12340000E);
      step(1, 16'h83F0, 1, 0); check("t2_li", dut_bundle, 36'h8300FFF02);
      step(1, 16'hD2F0, 1, 0); check("t2_jal", dut_bundle, 36'hD20000F02);
      step(1, 16'hB580, 1, 0); check("t2_biz", dut_bundle, 36'hB050FF808);
      step(0, 16'h0000, 1, 0);
      // T3: back-pressure fills the skid; head stays stable
      step(1, 16'h0111, 0, 0);
      step(1, 16'h0222, 0, 0); check("t3_in_ready", in_ready, 0);
      step(1, 16'h0333, 0, 0); check("t3_hold", dut_bundle, 36'h01110000E);
      step(0, 16'h0000, 1, 0); check("t3_in_ready_back", in_ready, 1);
      step(1, 16'h0333, 1, 0);
      step(0, 16'h0000, 1, 0);
      step(0, 16'h0000, 1, 0);
      // T4: flush while full with a simultaneous offer
      step(1, 16'h0444, 0, 0);
      step(1, 16'h0555, 0, 0);
      step(1, 16'h0666, 1, 1); check("t4_flushed", out_valid, 0);
      step(1, 16'h0777, 1, 0);
      step(0, 16'h0000, 1, 0);
      // T5: EOE halts; reserved funct flagged
      step(1, 16'hF0F1, 0, 0); check("t5_halted", halted, 1); check("t5_in_ready", in_ready, 0);
      step(1, 16'h1234, 1, 0);
      step(0, 16'h0000, 1, 0); check("t5_drained", out_valid, 0);
      do_reset();
      step(1, 16'hF0F5, 1, 0); check("t5_illegal", dut_bundle, 36'hF0F500001);
      // T6: async reset while two deep
      step(1, 16'h0888, 0, 0);
      step(1, 16'h0999, 0, 0);
      do_reset();
      // Random traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 3) do_reset();
         if ($urandom_range(0, 99) < 8) ins = {4'hF, 4'($urandom), 4'($urandom), 4'h1};
         else ins = 16'($urandom);
         step(1'($urandom_range(0, 99) < 70), ins, 1'($urandom_range(0, 99) < 65),
              1'($urandom_range(0, 99) < 5));
      end
      step(0, 16'h0000, 1, 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
